// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the 5-stage MIPS pipeline controller: opcodes, Funct
// codes, ALU operations, forwarding selects and the per-stage control words.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic [2:0] alu_control;
    logic       alu_src;
    logic       reg_dst;
  } e_word_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
  } m_word_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } w_word_t;

endpackage

// File: rtl/pipe_ctrl_hazard_unit.sv
// Combinational hazard detection: load-use and branch stalls plus the
// Decode- and Execute-stage forwarding selects.
module hazard_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int WR_W  = 6
) (
  input  logic [REG_W-1:0] a1,
  input  logic [REG_W-1:0] a2,
  input  logic [REG_W-1:0] rs_e,
  input  logic [REG_W-1:0] rt_e,
  input  logic [WR_W-1:0]  write_reg_e,
  input  logic [WR_W-1:0]  write_reg_m,
  input  logic [WR_W-1:0]  write_reg_w,
  input  logic             branch_d,
  input  logic             reg_write_e,
  input  logic             mem_to_reg_e,
  input  logic             reg_write_m,
  input  logic             mem_to_reg_m,
  input  logic             reg_write_w,
  output logic             stall,
  output logic             branch_stall,
  output logic             forward_ad,
  output logic             forward_bd,
  output logic [1:0]       forward_ae,
  output logic [1:0]       forward_be
);

  logic [REG_W-1:0] wr_e, wr_m, wr_w;
  logic             lw_stall;
  logic             unused_wr_hi;

  // Only the register-file address bits take part in the compares.
  assign wr_e = write_reg_e[REG_W-1:0];
  assign wr_m = write_reg_m[REG_W-1:0];
  assign wr_w = write_reg_w[REG_W-1:0];
  assign unused_wr_hi = ^{write_reg_e[WR_W-1:REG_W], write_reg_m[WR_W-1:REG_W],
                          write_reg_w[WR_W-1:REG_W]};

  function automatic fwd_e fwd_ex(input logic [REG_W-1:0] src,
                                  input logic we_m, input logic [REG_W-1:0] dst_m,
                                  input logic we_w, input logic [REG_W-1:0] dst_w);
    if (src != '0 && we_m && src == dst_m) return FWD_MEM;
    if (src != '0 && we_w && src == dst_w) return FWD_WB;
    return FWD_NONE;
  endfunction

  assign lw_stall     = mem_to_reg_e && (rt_e == a1 || rt_e == a2);
  assign branch_stall = branch_d &&
                        ((reg_write_e  && (wr_e == a1 || wr_e == a2)) ||
                         (mem_to_reg_m && (wr_m == a1 || wr_m == a2)));
  assign stall        = lw_stall || branch_stall;

  assign forward_ad = (a1 != '0) && reg_write_m && (a1 == wr_m);
  assign forward_bd = (a2 != '0) && reg_write_m && (a2 == wr_m);
  assign forward_ae = fwd_ex(rs_e, reg_write_m, wr_m, reg_write_w, wr_w);
  assign forward_be = fwd_ex(rt_e, reg_write_m, wr_m, reg_write_w, wr_w);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipelined MIPS controller: decodes the Decode-stage instruction, carries the
// control word through E/M/W and drives the datapath's hazard controls.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int WR_W  = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Funct,
  input  logic             branch_boolean,
  input  logic [REG_W-1:0] A1,
  input  logic [REG_W-1:0] A2,
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic [WR_W-1:0]  WriteRegE,
  input  logic [WR_W-1:0]  WriteRegM,
  input  logic [WR_W-1:0]  WriteRegW,
  output logic             MemToReg,
  output logic             RegWriteW,
  output logic             MemWrite,
  output logic             RegDstE,
  output logic             ALUSrcB,
  output logic [2:0]       ALUControlE,
  output logic             PCSrc,
  output logic             JumpC,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] stall_count
);

  e_word_t d_word, e_q;
  m_word_t m_q;
  w_word_t w_q;
  logic    branch_d, jump_d, stall, branch_stall;

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    d_word   = '0;
    branch_d = 1'b0;
    jump_d   = 1'b0;
    case (Opcode)
      OP_RTYPE: begin
        d_word.reg_dst   = 1'b1;
        d_word.reg_write = 1'b1;
        case (Funct)
          FN_ADD:  d_word.alu_control = ALU_ADD;
          FN_SUB:  d_word.alu_control = ALU_SUB;
          FN_AND:  d_word.alu_control = ALU_AND;
          FN_OR:   d_word.alu_control = ALU_OR;
          FN_SLT:  d_word.alu_control = ALU_SLT;
          default: begin
            d_word.alu_control = ALU_ADD;
            d_word.reg_write   = 1'b0;
          end
        endcase
      end
      OP_LW: begin
        d_word.reg_write   = 1'b1;
        d_word.alu_src     = 1'b1;
        d_word.mem_to_reg  = 1'b1;
        d_word.alu_control = ALU_ADD;
      end
      OP_SW: begin
        d_word.mem_write   = 1'b1;
        d_word.alu_src     = 1'b1;
        d_word.alu_control = ALU_ADD;
      end
      OP_BEQ: begin
        branch_d           = 1'b1;
        d_word.alu_control = ALU_SUB;
      end
      OP_ADDI: begin
        d_word.reg_write   = 1'b1;
        d_word.alu_src     = 1'b1;
        d_word.alu_control = ALU_ADD;
      end
      OP_J:    jump_d = 1'b1;
      default: ;
    endcase
  end

  hazard_unit #(.REG_W(REG_W), .WR_W(WR_W)) u_hazard (
    .a1           (A1),
    .a2           (A2),
    .rs_e         (RsE),
    .rt_e         (RtE),
    .write_reg_e  (WriteRegE),
    .write_reg_m  (WriteRegM),
    .write_reg_w  (WriteRegW),
    .branch_d     (branch_d),
    .reg_write_e  (e_q.reg_write),
    .mem_to_reg_e (e_q.mem_to_reg),
    .reg_write_m  (m_q.reg_write),
    .mem_to_reg_m (m_q.mem_to_reg),
    .reg_write_w  (w_q.reg_write),
    .stall        (stall),
    .branch_stall (branch_stall),
    .forward_ad   (ForwardAD),
    .forward_bd   (ForwardBD),
    .forward_ae   (ForwardAE),
    .forward_be   (ForwardBE)
  );

  // NOTE: state updates use non-blocking assignments so every stage register
  // samples the pre-edge value of the stage before it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q         <= '0;
      m_q         <= '0;
      w_q         <= '0;
      stall_count <= '0;
    end else begin
      e_q <= stall ? e_word_t'('0) : d_word;
      m_q <= '{e_q.reg_write, e_q.mem_to_reg, e_q.mem_write};
      w_q <= '{m_q.reg_write, m_q.mem_to_reg};
      if (stall && stall_count != '1) stall_count <= stall_count + 1'b1;
    end
  end

  assign RegDstE     = e_q.reg_dst;
  assign ALUSrcB     = e_q.alu_src;
  assign ALUControlE = e_q.alu_control;
  assign MemWrite    = m_q.mem_write;
  assign MemToReg    = w_q.mem_to_reg;
  assign RegWriteW   = w_q.reg_write;

  assign PCSrc  = branch_d && branch_boolean && !branch_stall;
  assign JumpC  = jump_d && !stall;
  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: decode table, hand-built hazard
// sequences and randomized cycles against an instruction-history model.
`timescale 1ns/1ps
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int         SAT_W  = 4;
  localparam logic [5:0] OP_BAD = 6'b111111;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [5:0]  Opcode, Funct;
  logic        branch_boolean;
  logic [4:0]  A1, A2, RsE, RtE;
  logic [5:0]  WriteRegE, WriteRegM, WriteRegW;
  logic        MemToReg, RegWriteW, MemWrite, RegDstE, ALUSrcB, PCSrc, JumpC;
  logic        StallF, StallD, FlushE, ForwardAD, ForwardBD;
  logic [2:0]  ALUControlE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [15:0] stall_count;
  logic [19:0] sat_unused;
  logic [SAT_W-1:0] sat_count;

  pipe_ctrl dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct),
    .branch_boolean(branch_boolean), .A1(A1), .A2(A2), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .MemToReg(MemToReg), .RegWriteW(RegWriteW), .MemWrite(MemWrite),
    .RegDstE(RegDstE), .ALUSrcB(ALUSrcB), .ALUControlE(ALUControlE),
    .PCSrc(PCSrc), .JumpC(JumpC), .StallF(StallF), .StallD(StallD),
    .FlushE(FlushE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .stall_count(stall_count)
  );

  // Narrow-counter twin so saturation is reachable in a short run.
  pipe_ctrl #(.CNT_W(SAT_W)) sat (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct),
    .branch_boolean(branch_boolean), .A1(A1), .A2(A2), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .MemToReg(sat_unused[0]), .RegWriteW(sat_unused[1]), .MemWrite(sat_unused[2]),
    .RegDstE(sat_unused[3]), .ALUSrcB(sat_unused[4]), .ALUControlE(sat_unused[7:5]),
    .PCSrc(sat_unused[8]), .JumpC(sat_unused[9]), .StallF(sat_unused[10]),
    .StallD(sat_unused[11]), .FlushE(sat_unused[12]), .ForwardAD(sat_unused[13]),
    .ForwardBD(sat_unused[14]), .ForwardAE(sat_unused[16:15]),
    .ForwardBE(sat_unused[18:17]), .stall_count(sat_count)
  );
  assign sat_unused[19] = 1'b0;

  typedef struct packed {
    logic [5:0] op; logic [5:0] fn; logic bb;
    logic [4:0] a1; logic [4:0] a2; logic [4:0] rs_e; logic [4:0] rt_e;
    logic [5:0] wr_e; logic [5:0] wr_m; logic [5:0] wr_w;
  } in_t;

  typedef struct packed {
    logic mtr, rww, mw, rde, src; logic [2:0] alu;
    logic pcs, jmp, stf, std, fle, fad, fbd;
    logic [1:0] fae, fbe; logic [15:0] cnt;
  } out_t;

  typedef struct packed {
    logic rw, mtr, mw; logic [2:0] alu; logic src, dst, br, jmp;
  } ctl_t;

  typedef struct packed {
    logic [5:0] op; logic [5:0] fn;
    logic dst, src; logic [2:0] alu; logic mw, rw, mtr, pcs, jmp;
  } dec_vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the control words of the last three instructions that entered E,
  // newest first, so [0] is in Execute, [1] in Memory, [2] in Writeback.
  ctl_t        hist[$];
  int unsigned m_cnt, m_sat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ctl_t decode(input logic [5:0] op, input logic [5:0] fn);
    ctl_t c = '0;
    if (op == OP_RTYPE) begin
      c.dst = 1'b1;
      c.rw  = 1'b1;
      if      (fn == FN_ADD) c.alu = 3'b010;
      else if (fn == FN_SUB) c.alu = 3'b110;
      else if (fn == FN_AND) c.alu = 3'b000;
      else if (fn == FN_OR)  c.alu = 3'b001;
      else if (fn == FN_SLT) c.alu = 3'b111;
      else begin c.alu = 3'b010; c.rw = 1'b0; end
    end else if (op == OP_LW)   begin c.rw = 1'b1; c.src = 1'b1; c.mtr = 1'b1; c.alu = 3'b010; end
    else if (op == OP_SW)   begin c.mw = 1'b1; c.src = 1'b1; c.alu = 3'b010; end
    else if (op == OP_BEQ)  begin c.br = 1'b1; c.alu = 3'b110; end
    else if (op == OP_ADDI) begin c.rw = 1'b1; c.src = 1'b1; c.alu = 3'b010; end
    else if (op == OP_J)    c.jmp = 1'b1;
    return c;
  endfunction

  function automatic logic [1:0] fwd(input logic [4:0] r, input logic mrw, input logic [4:0] wm,
                                     input logic wrw, input logic [4:0] ww);
    if (r != 0 && mrw && r == wm) return 2'b10;
    if (r != 0 && wrw && r == ww) return 2'b01;
    return 2'b00;
  endfunction

  function automatic out_t expect_out();
    ctl_t d, e, m, w;
    out_t x;
    logic [4:0] we, wm, ww;
    logic lw, bs;
    d = decode(Opcode, Funct);
    e = hist[0]; m = hist[1]; w = hist[2];
    we = WriteRegE[4:0]; wm = WriteRegM[4:0]; ww = WriteRegW[4:0];
    lw = e.mtr && (RtE == A1 || RtE == A2);
    bs = d.br && ((e.rw && (we == A1 || we == A2)) || (m.mtr && (wm == A1 || wm == A2)));
    x.mtr = w.mtr; x.rww = w.rw; x.mw = m.mw;
    x.rde = e.dst; x.src = e.src; x.alu = e.alu;
    x.pcs = d.br && branch_boolean && !bs;
    x.jmp = d.jmp && !(lw || bs);
    x.stf = lw || bs; x.std = lw || bs; x.fle = lw || bs;
    x.fad = (A1 != 0) && m.rw && (A1 == wm);
    x.fbd = (A2 != 0) && m.rw && (A2 == wm);
    x.fae = fwd(RsE, m.rw, wm, w.rw, ww);
    x.fbe = fwd(RtE, m.rw, wm, w.rw, ww);
    x.cnt = 16'(m_cnt);
    return x;
  endfunction

  task automatic model_reset();
    hist = {};
    repeat (3) hist.push_back(ctl_t'(0));
    m_cnt = 0;
    m_sat = 0;
  endtask

  function automatic in_t mk(input logic [5:0] op, input logic [5:0] fn, input logic bb,
                             input logic [4:0] a1, input logic [4:0] a2,
                             input logic [4:0] rs, input logic [4:0] rt,
                             input logic [5:0] we, input logic [5:0] wm, input logic [5:0] ww);
    in_t v;
    v.op = op; v.fn = fn; v.bb = bb; v.a1 = a1; v.a2 = a2; v.rs_e = rs; v.rt_e = rt;
    v.wr_e = we; v.wr_m = wm; v.wr_w = ww;
    return v;
  endfunction

  // Apply inputs just after a rising edge, compare at the following falling edge.
  task automatic drive(input in_t v, input string tag);
    out_t ex, ac;
    Opcode = v.op; Funct = v.fn; branch_boolean = v.bb;
    A1 = v.a1; A2 = v.a2; RsE = v.rs_e; RtE = v.rt_e;
    WriteRegE = v.wr_e; WriteRegM = v.wr_m; WriteRegW = v.wr_w;
    @(negedge clk);
    ex = expect_out();
    ac = '{MemToReg, RegWriteW, MemWrite, RegDstE, ALUSrcB, ALUControlE, PCSrc, JumpC,
           StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE, stall_count};
    check(tag, 64'(ac), 64'(ex));
    check({tag, "_sat"}, 64'(sat_count), 64'(m_sat));
  endtask

  task automatic tick();
    out_t ex;
    ctl_t d;
    @(posedge clk);
    ex = expect_out();
    d  = decode(Opcode, Funct);
    if (!reset) model_reset();
    else begin
      if (ex.stf) begin
        d = '0;
        if (m_cnt != 32'hFFFF) m_cnt++;
        if (m_sat != (1 << SAT_W) - 1) m_sat++;
      end
      hist.push_front(d);
      void'(hist.pop_back());
    end
    #1;
  endtask

  in_t nop_v;

  task automatic idle(input int n);
    repeat (n) begin drive(nop_v, "idle"); tick(); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    dec_vec_t tbl[12];
    in_t v;
    logic [5:0] ops[7];
    logic [5:0] fns[6];

    tbl[0]  = '{OP_RTYPE, FN_ADD,    1'b1, 1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{OP_RTYPE, FN_SUB,    1'b1, 1'b0, 3'b110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{OP_RTYPE, FN_AND,    1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{OP_RTYPE, FN_OR,     1'b1, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{OP_RTYPE, FN_SLT,    1'b1, 1'b0, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{OP_RTYPE, 6'b000001, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{OP_LW,    6'd0,      1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{OP_SW,    6'd0,      1'b0, 1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{OP_BEQ,   6'd0,      1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{OP_ADDI,  6'd0,      1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{OP_J,     6'd0,      1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{OP_BAD,   6'd0,      1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    nop_v = mk(OP_BAD, 6'd0, 1'b0, 5'd1, 5'd2, 5'd7, 5'd8, 6'd9, 6'd10, 6'd11);
    model_reset();

    // Reset state.
    drive(nop_v, "reset_state");
    check("reset_cnt", 64'(stall_count), 64'd0);
    check("reset_rww", 64'(RegWriteW), 64'd0);
    tick();
    reset = 1'b1;
    idle(2);

    // Decode table, each instruction followed through E, M and W.
    for (int i = 0; i < 12; i++) begin
      v = nop_v; v.op = tbl[i].op; v.fn = tbl[i].fn; v.bb = 1'b1;
      drive(v, $sformatf("tbl%0d_d", i));
      check($sformatf("tbl%0d_pcsrc", i), 64'(PCSrc), 64'(tbl[i].pcs));
      check($sformatf("tbl%0d_jump", i), 64'(JumpC), 64'(tbl[i].jmp));
      tick();
      drive(nop_v, $sformatf("tbl%0d_e", i));
      check($sformatf("tbl%0d_e_word", i), 64'({RegDstE, ALUSrcB, ALUControlE}),
            64'({tbl[i].dst, tbl[i].src, tbl[i].alu}));
      tick();
      drive(nop_v, $sformatf("tbl%0d_m", i));
      check($sformatf("tbl%0d_memwrite", i), 64'(MemWrite), 64'(tbl[i].mw));
      tick();
      drive(nop_v, $sformatf("tbl%0d_w", i));
      check($sformatf("tbl%0d_w_word", i), 64'({RegWriteW, MemToReg}),
            64'({tbl[i].rw, tbl[i].mtr}));
      tick();
    end

    // lw $2,0($0) ; add $4,$2,$1 : one-cycle load-use stall.
    idle(3);
    drive(mk(OP_LW, 6'd0, 1'b0, 5'd0, 5'd2, 5'd7, 5'd8, 6'd9, 6'd10, 6'd11), "lu_lw");
    tick();
    drive(mk(OP_RTYPE, FN_ADD, 1'b0, 5'd2, 5'd1, 5'd0, 5'd2, 6'd2, 6'd10, 6'd11), "lu_stall");
    check("lu_stall_f", 64'({StallF, StallD, FlushE}), 64'h7);
    tick();
    drive(mk(OP_RTYPE, FN_ADD, 1'b0, 5'd2, 5'd1, 5'd0, 5'd0, 6'd0, 6'd2, 6'd11), "lu_bubble");
    check("lu_one_cycle", 64'({StallF, StallD, FlushE}), 64'h0);
    check("lu_bubble_e", 64'({RegDstE, ALUSrcB, ALUControlE}), 64'h0);
    tick();
    drive(mk(OP_BAD, 6'd0, 1'b0, 5'd1, 5'd2, 5'd2, 5'd1, 6'd4, 6'd0, 6'd2), "lu_fwd");
    check("lu_fwd_ae", 64'(ForwardAE), 64'b01);
    check("lu_count", 64'(stall_count), 64'd1);
    tick();

    // add $3,$1,$2 ; sub $4,$3,$1 : Memory-stage forward into Execute.
    idle(3);
    drive(mk(OP_RTYPE, FN_ADD, 1'b0, 5'd1, 5'd2, 5'd7, 5'd8, 6'd9, 6'd10, 6'd11), "fw_add");
    tick();
    drive(mk(OP_RTYPE, FN_SUB, 1'b0, 5'd3, 5'd1, 5'd1, 5'd2, 6'd3, 6'd10, 6'd11), "fw_sub");
    tick();
    drive(mk(OP_BAD, 6'd0, 1'b0, 5'd1, 5'd2, 5'd3, 5'd1, 6'd4, 6'd3, 6'd0), "fw_e");
    check("fw_ae_mem", 64'(ForwardAE), 64'b10);
    check("fw_be_none", 64'(ForwardBE), 64'b00);
    tick();
    drive(mk(OP_BAD, 6'd0, 1'b0, 5'd1, 5'd2, 5'd7, 5'd8, 6'd0, 6'd4, 6'd3), "fw_next");
    check("fw_ae_clear", 64'(ForwardAE), 64'b00);
    tick();

    // add $5,... ; beq $5,$6 : branch stall, then Decode forward and taken branch.
    idle(3);
    drive(mk(OP_RTYPE, FN_ADD, 1'b0, 5'd1, 5'd2, 5'd7, 5'd8, 6'd9, 6'd10, 6'd11), "br_add");
    tick();
    drive(mk(OP_BEQ, 6'd0, 1'b1, 5'd5, 5'd6, 5'd1, 5'd2, 6'd5, 6'd10, 6'd11), "br_stall");
    check("br_stall_pcsrc", 64'({PCSrc, StallF}), 64'b01);
    tick();
    drive(mk(OP_BEQ, 6'd0, 1'b1, 5'd5, 5'd6, 5'd0, 5'd0, 6'd0, 6'd5, 6'd11), "br_go");
    check("br_go", 64'({ForwardAD, ForwardBD, PCSrc, StallF}), 64'b1010);
    tick();

    // j ; unknown opcode 111111 through every stage.
    idle(3);
    drive(mk(OP_J, 6'd0, 1'b0, 5'd1, 5'd2, 5'd7, 5'd8, 6'd9, 6'd10, 6'd11), "j_d");
    check("j_jumpc", 64'(JumpC), 64'd1);
    tick();
    drive(nop_v, "bad_d");
    check("bad_jumpc", 64'(JumpC), 64'd0);
    tick();
    drive(nop_v, "bad_e");
    check("bad_alu_e", 64'({RegDstE, ALUSrcB, ALUControlE}), 64'h0);
    tick();
    drive(nop_v, "bad_m");
    check("bad_memwrite", 64'(MemWrite), 64'd0);
    tick();
    drive(nop_v, "bad_w");
    check("bad_regwrite", 64'({RegWriteW, MemToReg}), 64'd0);
    tick();

    // Back-to-back loads stall every other cycle until the narrow counter saturates.
    repeat (40) begin
      drive(mk(OP_LW, 6'd0, 1'b0, 5'd2, 5'd2, 5'd7, 5'd2, 6'd9, 6'd10, 6'd11), "sat_run");
      tick();
    end
    check("sat_hold", 64'(sat_count), 64'hF);

    // Asynchronous reset with loads in flight in E, M and W.
    idle(3);
    repeat (3) begin
      drive(mk(OP_LW, 6'd0, 1'b0, 5'd1, 5'd2, 5'd7, 5'd8, 6'd9, 6'd10, 6'd11), "rs_fill");
      tick();
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("rs_regs", 64'({MemToReg, RegWriteW, MemWrite, RegDstE, ALUSrcB, ALUControlE}), 64'h0);
    check("rs_count", 64'({stall_count, sat_count}), 64'h0);
    drive(nop_v, "rs_low");
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(nop_v, $sformatf("rs_rel%0d", i));
      check($sformatf("rs_no_write%0d", i), 64'(RegWriteW), 64'd0);
      tick();
    end

    // Randomized cycles against the model, with occasional reset pulses.
    ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, 6'd0};
    fns = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, 6'd0};
    for (int i = 0; i < 500; i++) begin
      ops[6] = 6'($urandom_range(0, 63));
      fns[5] = 6'($urandom_range(0, 63));
      v.op   = ops[$urandom_range(0, 6)];
      v.fn   = fns[$urandom_range(0, 5)];
      v.bb   = 1'($urandom_range(0, 1));
      v.a1   = 5'($urandom_range(0, 3));
      v.a2   = 5'($urandom_range(0, 3));
      v.rs_e = 5'($urandom_range(0, 3));
      v.rt_e = 5'($urandom_range(0, 3));
      v.wr_e = {1'($urandom_range(0, 1)), 3'b000, 2'($urandom_range(0, 3))};
      v.wr_m = {1'($urandom_range(0, 1)), 3'b000, 2'($urandom_range(0, 3))};
      v.wr_w = {1'($urandom_range(0, 1)), 3'b000, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b0;
        model_reset();
      end
      drive(v, "rand");
      tick();
      reset = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipelined controller and hazard unit for the 5-stage MIPS datapath.
- Decodes Opcode/Funct of the instruction in Decode and carries the control word through E/M/W pipeline registers.
- Generates PCSrc/JumpC, stall, flush and forwarding selects, consuming the datapath's register addresses and branch_boolean.
- Sits directly upstream of the datapath and drives all of its control inputs.

Parameters:
- REG_W, 5, register-file address width (RsD/RtD/RsE/RtE compares).
- WR_W, 6, width of WriteRegE/M/W inputs; only bits [REG_W-1:0] are compared.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Opcode  in  6  InstrD[31:26]
- Funct  in  6  InstrD[5:0]
- branch_boolean  in  1  Decode-stage equality compare result
- A1  in  REG_W  RsD
- A2  in  REG_W  RtD
- RsE  in  REG_W  Rs in Execute
- RtE  in  REG_W  Rt in Execute
- WriteRegE  in  WR_W  destination register in Execute
- WriteRegM  in  WR_W  destination register in Memory
- WriteRegW  in  WR_W  destination register in Writeback
- MemToReg  out  1  W-stage result select
- RegWriteW  out  1  W-stage register-file write enable
- MemWrite  out  1  M-stage store enable
- RegDstE  out  1  E-stage destination select
- ALUSrcB  out  1  E-stage immediate select
- ALUControlE  out  3  E-stage ALU operation
- PCSrc  out  1  take branch
- JumpC  out  1  take jump
- StallF  out  1  stall fetch
- StallD  out  1  stall decode
- FlushE  out  1  flush execute
- ForwardAD  out  1  Decode A forward select
- ForwardBD  out  1  Decode B forward select
- ForwardAE  out  2  Execute A forward select
- ForwardBE  out  2  Execute B forward select
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Decode (combinational, D stage):
  - R-type 000000: RegWrite=1, RegDst=1, ALU from Funct.
  - lw 100011: RegWrite=1, ALUSrc=1, MemToReg=1, add.
  - sw 101011: MemWrite=1, ALUSrc=1, add.
  - beq 000100: Branch=1, sub.
  - addi 001000: RegWrite=1, ALUSrc=1, add.
  - j 000010: Jump=1.
  - Any other opcode: all controls 0 (nop).
- ALUControl encoding: add 010, sub 110, and 000, or 001, slt 111.
- Funct decode for R-type: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other Funct gives 010 with RegWrite=0.
- E register {RegWrite, MemToReg, MemWrite, ALUControl, ALUSrc, RegDst}: loads the D word each rising edge; loads all-zero when FlushE=1.
- M register {RegWrite, MemToReg, MemWrite}: loads from E each cycle; never stalled.
- W register {RegWrite, MemToReg}: loads from M each cycle; never stalled.
- Output stage mapping: RegDstE, ALUSrcB, ALUControlE from E; MemWrite from M; MemToReg, RegWriteW from W.
- Latency: an instruction's D decode appears on E outputs 1 cycle later, on MemWrite 2 cycles later, on MemToReg/RegWriteW 3 cycles later.
- lwstall = MemToRegE & (RtE==A1 | RtE==A2).
- branchstall = BranchD & ((RegWriteE & (WriteRegE==A1 | WriteRegE==A2)) | (MemToRegM & (WriteRegM==A1 | WriteRegM==A2))).
- StallF = StallD = FlushE = lwstall | branchstall.
- PCSrc = BranchD & branch_boolean & ~branchstall.
- JumpC = JumpD & ~StallD.
- ForwardAE:
  - 10 if RsE!=0 & RegWriteM & RsE==WriteRegM;
  - else 01 if RsE!=0 & RegWriteW & RsE==WriteRegW;
  - else 00.
  - M stage has priority. ForwardBE is identical using RtE.
- ForwardAD = A1!=0 & RegWriteM & A1==WriteRegM. ForwardBD is identical using A2.
- Register 0 never forwards and never triggers a stall via forwarding compare; lwstall on $0 is permitted (conservative).
- stall_count increments by 1 on each rising edge with StallF=1 and saturates at all-ones.
- Reset (asserted low, asynchronous): all E/M/W registers and stall_count go to 0 immediately.
  - Consequently MemToReg, RegWriteW, MemWrite, RegDstE, ALUSrcB, ALUControlE, stall_count = 0.
  - Combinational outputs follow from the zeroed state and the inputs.
  - Reset mid-instruction discards all in-flight control; no writes occur while reset is low.

Decomposition:
- Shared package pipe_ctrl_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), Funct constants, ALU control constants, FWD_NONE=00 / FWD_WB=01 / FWD_MEM=10.
- One sub-module, hazard_unit: purely combinational stall/flush/forward equations. Pipeline registers, decode and stall_count stay in pipe_ctrl.

Test Plan:
- Reset low mid-stream with lw in E/M/W -> all registered outputs 0 within the same cycle, stall_count=0, no RegWriteW pulse after release.
- add $3,$1,$2 followed by sub $4,$3,$1 -> in the sub's E cycle ForwardAE=10, ForwardBE=00; one cycle later, with an independent instruction in E, ForwardAE=00.
- lw $2,0($0) followed by add $4,$2,$1 -> StallF=StallD=FlushE=1 for exactly 1 cycle, next E word all-zero, then ForwardAE=01, stall_count=1.
- add $5,... followed by beq $5,$6 -> branchstall 1 cycle with PCSrc=0 despite branch_boolean=1; next cycle ForwardAD=1, PCSrc=1.
- j followed by unknown opcode 111111 -> JumpC=1 in j's D cycle; for the unknown op, ALUControlE=000, RegWriteW=0 and MemWrite=0 through all stages.
- Force 65,536+ stall cycles -> stall_count holds at 16'hFFFF.
